// File: rtl/turf_rdwr_arbiter.sv
// Round-robin arbiter sharing one rdwr target bus among NUM_HOSTS masters,
// with a watchdog that force-completes hung cycles using TIMEOUT_DATA.
module turf_rdwr_arbiter #(
    parameter int          NUM_HOSTS    = 2,
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_HOSTS-1:0]      s_en_i,
    input  logic [NUM_HOSTS-1:0]      s_wr_i,
    input  logic [28*NUM_HOSTS-1:0]   s_adr_i,
    input  logic [32*NUM_HOSTS-1:0]   s_dat_i,
    output logic [NUM_HOSTS-1:0]      s_ack_o,
    output logic [31:0]               s_dat_o,
    output logic                      m_en_o,
    output logic                      m_wr_o,
    output logic [27:0]               m_adr_o,
    output logic [31:0]               m_dat_o,
    input  logic                      m_ack_i,
    input  logic [31:0]               m_dat_i,
    output logic [NUM_HOSTS-1:0]      grant_o,
    output logic                      timeout_o
);

    localparam int IDX_W = $clog2(NUM_HOSTS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic [WD_W-1:0]    wd_cnt_q;
    logic               timeout_q;

    logic [IDX_W-1:0]   pick_d;
    logic               busy_s;
    logic               wd_expire_s;
    logic               done_s;

    // Round-robin pick: first requester after the last granted index, wrapping.
    always_comb begin
        int unsigned c;
        logic        found;
        pick_d = last_idx_q;
        found  = 1'b0;
        c      = 0;
        for (int i = 1; i <= NUM_HOSTS; i++) begin
            c = (int'(last_idx_q) + i) % NUM_HOSTS;
            if (!found && s_en_i[c[IDX_W-1:0]]) begin
                found  = 1'b1;
                pick_d = c[IDX_W-1:0];
            end else begin
                found  = found;
            end
        end
    end

    assign busy_s      = (state_q == ST_BUSY);
    assign wd_expire_s = (wd_cnt_q == WD_W'(TIMEOUT - 1));
    assign done_s      = busy_s & (m_ack_i | wd_expire_s);
    assign timeout_o   = timeout_q;

    // Target-side forwarding and same-cycle completion back to the granted master.
    always_comb begin
        s_ack_o = '0;
        s_dat_o = 32'h0000_0000;
        m_en_o  = 1'b0;
        m_wr_o  = 1'b0;
        m_adr_o = 28'h000_0000;
        m_dat_o = 32'h0000_0000;
        grant_o = '0;
        if (busy_s) begin
            m_en_o  = s_en_i[gnt_idx_q];
            m_wr_o  = s_wr_i[gnt_idx_q];
            m_adr_o = s_adr_i[28*gnt_idx_q +: 28];
            m_dat_o = s_dat_i[32*gnt_idx_q +: 32];
            grant_o = {{(NUM_HOSTS-1){1'b0}}, 1'b1} << gnt_idx_q;
        end else begin
            m_en_o  = 1'b0;
        end
        if (done_s) begin
            s_ack_o = {{(NUM_HOSTS-1){1'b0}}, 1'b1} << gnt_idx_q;
            s_dat_o = m_ack_i ? m_dat_i : TIMEOUT_DATA;
        end else begin
            s_ack_o = '0;
        end
    end

    // Arbitration FSM with watchdog; a late m_ack_i in IDLE is ignored.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(NUM_HOSTS - 1);
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|s_en_i) begin
                        gnt_idx_q  <= pick_d;
                        last_idx_q <= pick_d;
                        wd_cnt_q   <= '0;
                        state_q    <= ST_BUSY;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= ~m_ack_i;
                    end else if (!s_en_i[gnt_idx_q]) begin
                        state_q   <= ST_IDLE;
                    end else if (wd_cnt_q != {WD_W{1'b1}}) begin
                        wd_cnt_q  <= wd_cnt_q + WD_W'(1);
                    end else begin
                        wd_cnt_q  <= wd_cnt_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turf_rdwr_arbiter.sv
// Directed-step bench for turf_rdwr_arbiter (2 masters, TIMEOUT=16).
module tb_turf_rdwr_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [1:0]  s_en_i;
    logic [1:0]  s_wr_i;
    logic [55:0] s_adr_i;
    logic [63:0] s_dat_i;
    logic [1:0]  s_ack_o;
    logic [31:0] s_dat_o;
    logic        m_en_o;
    logic        m_wr_o;
    logic [27:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int total;
    int bad;

    turf_rdwr_arbiter #(
        .NUM_HOSTS(2),
        .TIMEOUT(16),
        .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_en_i(s_en_i), .s_wr_i(s_wr_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
        .m_en_o(m_en_o), .m_wr_o(m_wr_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        aresetn = 1'b0;
        s_en_i  = 2'b00;
        s_wr_i  = 2'b00;
        s_adr_i = 56'h0;
        s_dat_i = 64'h0;
        m_ack_i = 1'b0;
        m_dat_i = 32'h0;

        // reset
        tick(); tick(); tick();
        #1;
        chk("rst_m_en", {31'd0, m_en_o}, 32'd0);
        chk("rst_grant", {30'd0, grant_o}, 32'd0);
        chk("rst_s_ack", {30'd0, s_ack_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        chk("rst_m_adr", {4'd0, m_adr_o}, 32'd0);
        aresetn = 1'b1;
        tick();

        // master 0 read, ack 3 cycles after m_en_o
        s_en_i = 2'b01;
        s_adr_i[27:0] = 28'h0000010;
        #1;
        chk("rd_cyc0_m_en", {31'd0, m_en_o}, 32'd0);
        tick(); #1;
        chk("rd_cyc1_m_en", {31'd0, m_en_o}, 32'd1);
        chk("rd_cyc1_m_adr", {4'd0, m_adr_o}, 32'h0000010);
        chk("rd_cyc1_m_wr", {31'd0, m_wr_o}, 32'd0);
        chk("rd_cyc1_grant", {30'd0, grant_o}, 32'd1);
        chk("rd_cyc1_s_ack", {30'd0, s_ack_o}, 32'd0);
        tick(); tick(); tick();
        m_ack_i = 1'b1;
        m_dat_i = 32'h12345678;
        #1;
        chk("rd_ack_s_ack", {30'd0, s_ack_o}, 32'd1);
        chk("rd_ack_s_dat", s_dat_o, 32'h12345678);
        tick();
        m_ack_i = 1'b0;
        m_dat_i = 32'h0;
        s_en_i  = 2'b00;
        #1;
        chk("rd_idle_m_en", {31'd0, m_en_o}, 32'd0);
        chk("rd_idle_grant", {30'd0, grant_o}, 32'd0);
        chk("rd_idle_timeout", {31'd0, timeout_o}, 32'd0);
        chk("rd_idle_s_dat", s_dat_o, 32'd0);

        // round robin after fresh reset: 0,1,0,1
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        s_en_i  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            m_ack_i = 1'b1;
            #1;
            chk("rr_grant", {30'd0, grant_o}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_s_ack", {30'd0, s_ack_o}, (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            m_ack_i = 1'b0;
            if (k == 3) s_en_i = 2'b00;
            #1;
            chk("rr_idle_grant", {30'd0, grant_o}, 32'd0);
        end

        // master 1 write
        s_en_i = 2'b10;
        s_wr_i = 2'b10;
        s_adr_i[55:28] = 28'h0000004;
        s_dat_i[63:32] = 32'hCAFEF00D;
        tick(); #1;
        chk("wr_grant", {30'd0, grant_o}, 32'd2);
        chk("wr_m_wr", {31'd0, m_wr_o}, 32'd1);
        chk("wr_m_adr", {4'd0, m_adr_o}, 32'h0000004);
        chk("wr_m_dat", m_dat_o, 32'hCAFEF00D);
        m_ack_i = 1'b1;
        #1;
        chk("wr_s_ack", {30'd0, s_ack_o}, 32'd2);
        tick();
        m_ack_i = 1'b0;
        s_en_i  = 2'b00;
        s_wr_i  = 2'b00;
        #1;

        // timeout: target never acks
        s_en_i = 2'b01;
        s_adr_i[27:0] = 28'h0000020;
        tick();
        for (int c = 1; c < 16; c++) begin
            #1;
            chk("to_wait_s_ack", {30'd0, s_ack_o}, 32'd0);
            tick();
        end
        #1;
        chk("to_s_ack", {30'd0, s_ack_o}, 32'd1);
        chk("to_s_dat", s_dat_o, 32'hDEADBEEF);
        chk("to_timeout_early", {31'd0, timeout_o}, 32'd0);
        tick();
        s_en_i = 2'b00;
        #1;
        chk("to_pulse", {31'd0, timeout_o}, 32'd1);
        chk("to_idle_grant", {30'd0, grant_o}, 32'd0);
        m_ack_i = 1'b1;
        m_dat_i = 32'h11112222;
        #1;
        chk("late_ack_s_ack", {30'd0, s_ack_o}, 32'd0);
        chk("late_ack_s_dat", s_dat_o, 32'd0);
        tick();
        m_ack_i = 1'b0;
        #1;
        chk("to_pulse_end", {31'd0, timeout_o}, 32'd0);

        // ack exactly on watchdog cycle 16: ack wins
        s_en_i = 2'b01;
        tick();
        for (int c = 1; c < 16; c++) tick();
        m_ack_i = 1'b1;
        m_dat_i = 32'hA5A50001;
        #1;
        chk("edge_s_ack", {30'd0, s_ack_o}, 32'd1);
        chk("edge_s_dat", s_dat_o, 32'hA5A50001);
        tick();
        m_ack_i = 1'b0;
        s_en_i  = 2'b00;
        #1;
        chk("edge_no_timeout", {31'd0, timeout_o}, 32'd0);

        // reset mid-BUSY
        s_en_i = 2'b10;
        tick(); #1;
        chk("mid_grant", {30'd0, grant_o}, 32'd2);
        tick();
        aresetn = 1'b0;
        #1;
        chk("mid_rst_s_ack", {30'd0, s_ack_o}, 32'd0);
        tick(); #1;
        chk("mid_rst_m_en", {31'd0, m_en_o}, 32'd0);
        chk("mid_rst_grant", {30'd0, grant_o}, 32'd0);
        chk("mid_rst_s_ack2", {30'd0, s_ack_o}, 32'd0);
        aresetn = 1'b1;
        tick(); #1;
        chk("post_rst_grant", {30'd0, grant_o}, 32'd2);
        chk("post_rst_m_en", {31'd0, m_en_o}, 32'd1);

        // abort: granted master drops s_en_i
        s_en_i = 2'b00;
        #1;
        chk("abort_s_ack", {30'd0, s_ack_o}, 32'd0);
        chk("abort_m_en", {31'd0, m_en_o}, 32'd0);
        tick(); #1;
        chk("abort_grant", {30'd0, grant_o}, 32'd0);
        chk("abort_timeout", {31'd0, timeout_o}, 32'd0);
        s_en_i = 2'b01;
        tick(); #1;
        chk("after_abort_grant", {30'd0, grant_o}, 32'd1);
        m_ack_i = 1'b1;
        m_dat_i = 32'h0BADF00D;
        #1;
        chk("after_abort_s_dat", s_dat_o, 32'h0BADF00D);
        tick();
        m_ack_i = 1'b0;
        s_en_i  = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
